// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
//   Shares one serial LED strip driver between two GRB frame sources.
//   Requests are arbitrated round-robin while idle; the winning frame is
//   copied into a shadow register and streamed one 24-bit pixel at a time
//   over a valid/ready handshake. After the last pixel the line is held idle
//   for the strip latch gap, then frame_done pulses for one cycle.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   req_a/frame_a      game engine request (level) and frame, LED0 in MSBs
//   req_b/frame_b      animation request (level) and frame, same packing
//   gnt_a/gnt_b        one-cycle pulse when the matching frame is captured
//   px_data/px_valid   pixel word to the serializer and its valid
//   px_ready           serializer accepts px_data this cycle
//   busy               high while sending or in the latch gap
//   frame_done         one-cycle pulse at the end of the latch gap
//   last_src           source of the most recent grant (0=A, 1=B)
module led_frame_scheduler #(
  parameter int NUM_LEDS     = 5,
  parameter int LATCH_CYCLES = 6000,
  localparam int FW          = 24 * NUM_LEDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic [FW-1:0] frame_a,
  input  logic          req_b,
  input  logic [FW-1:0] frame_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic [23:0]   px_data,
  output logic          px_valid,
  input  logic          px_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          last_src
);

  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CW = $clog2(LATCH_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] shadow;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;

  logic          grant;
  logic          grant_b;
  logic          last_px;
  logic          latch_end;
  logic [FW-1:0] sel_frame;

  // Pixel view of the shadow copy, LED0 at index 0.
  logic [NUM_LEDS-1:0][23:0] pix;

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_pix
    assign pix[g] = shadow[FW-1-24*g -: 24];
  end

  assign last_px   = (idx == IW'(NUM_LEDS - 1));
  assign latch_end = (cnt == CW'(LATCH_CYCLES - 1));
  assign sel_frame = grant_b ? frame_b : frame_a;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_b    = 1'b0;
    case (state)
      IDLE: begin
        // A grant in the reset cycle would be lost, so never report one.
        if (!reset && (req_a || req_b)) begin
          grant     = 1'b1;
          // On a tie, the source that did not win last time goes next.
          grant_b   = req_b && (!req_a || !last_src);
          state_nxt = SEND;
        end
      end
      SEND:    if (px_ready && last_px) state_nxt = LATCH;
      LATCH:   if (latch_end)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_a      = grant && !grant_b;
  assign gnt_b      = grant && grant_b;
  assign px_valid   = (state == SEND);
  assign busy       = (state != IDLE);
  assign frame_done = (state == LATCH) && latch_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shadow   <= '0;
      idx      <= '0;
      cnt      <= '0;
      px_data  <= '0;
      last_src <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            shadow   <= sel_frame;
            last_src <= grant_b;
            idx      <= '0;
            // First pixel comes straight from the input so it is valid
            // on the very first SEND cycle.
            px_data  <= sel_frame[FW-1 -: 24];
          end
        end
        SEND: begin
          if (px_ready) begin
            if (last_px) begin
              idx     <= '0;
              cnt     <= '0;
              px_data <= '0;
            end else begin
              idx     <= idx + IW'(1);
              px_data <= pix[idx + IW'(1)];
            end
          end
        end
        LATCH: begin
          if (latch_end) cnt <= '0;
          else           cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler: table of arbitration/frame
// vectors, hand-written reset and late-request sequences, and randomized
// frames checked against a pixel-list / round-robin reference model.
module tb_led_frame_scheduler;

  localparam int NL = 5;
  localparam int LC = 6000;
  localparam int FW = 24 * NL;

  logic          clk;
  logic          reset;
  logic          req_a, req_b;
  logic [FW-1:0] frame_a, frame_b;
  logic          gnt_a, gnt_b;
  logic [23:0]   px_data;
  logic          px_valid;
  logic          px_ready;
  logic          busy;
  logic          frame_done;
  logic          last_src;

  int total  = 0;
  int passed = 0;

  led_frame_scheduler #(.NUM_LEDS(NL), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .frame_a(frame_a),
    .req_b(req_b), .frame_b(frame_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .busy(busy), .frame_done(frame_done), .last_src(last_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else passed++;
  endtask

  task automatic chkd(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %06h expected %06h", name, act, exp);
    else passed++;
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  // Pixel i of a frame: LED0 sits in the most significant 24 bits.
  function automatic logic [23:0] pix_of(input logic [FW-1:0] f, input int i);
    return 24'(f >> (24 * (NL - 1 - i)));
  endfunction

  function automatic logic [FW-1:0] rnd_frame();
    return FW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // Called in the grant cycle (inputs driven, outputs sampled). Follows the
  // frame through SEND and LATCH. mode: 0 ready=1, 1 ready 1,0,0 repeating,
  // 2 random ready with both frame inputs scrambled every cycle.
  // drop: 0 keep requests, 1 drop the granted one, 2 drop both.
  task automatic do_frame(input logic [FW-1:0] f, input logic src_b, input int mode,
                          input int drop, input logic zap, input int abort_hs,
                          input int abort_latch, input logic raise_b);
    int hs, k, n, bad, bcnt;
    logic rdy;
    chkb("gnt_a", gnt_a, !src_b);
    chkb("gnt_b", gnt_b, src_b);
    chkb("busy_at_gnt", busy, 1'b0);
    hs = 0; k = 0; bcnt = 0;
    while (hs < NL && k < 200) begin
      @(negedge clk);
      if (k == 0) begin
        if (drop == 2) begin req_a = 1'b0; req_b = 1'b0; end
        else if (drop == 1) begin if (src_b) req_b = 1'b0; else req_a = 1'b0; end
      end
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (k % 3 == 0);
      else                rdy = 1'($urandom_range(0, 1));
      px_ready = rdy;
      if (zap && k == 1) frame_a = '0;
      if (mode == 2) begin frame_a = rnd_frame(); frame_b = rnd_frame(); end
      #2;
      chkb("px_valid_send", px_valid, 1'b1);
      chkd("px_data", px_data, pix_of(f, hs));
      chkb("busy_send", busy, 1'b1);
      chkb("no_gnt_send", gnt_a | gnt_b, 1'b0);
      chkb("last_src", last_src, src_b);
      if (busy) bcnt++;
      k++;
      if (rdy) hs++;
      if (hs == abort_hs) return;
    end
    chki("handshakes", hs, NL);
    if (mode == 0) chki("send_cycles", k, NL);
    if (mode == 1) chki("send_cycles_stall", k, 3 * NL - 2);
    n = 0; bad = 0;
    do begin
      @(negedge clk);
      px_ready = 1'($urandom_range(0, 1));
      if (raise_b && n == LC / 2) req_b = 1'b1;
      #2;
      n++;
      if (busy) bcnt++;
      if (px_valid !== 1'b0 || px_data !== 24'h0 || busy !== 1'b1 || gnt_a || gnt_b) bad++;
      if (abort_latch != 0 && n == abort_latch) return;
    end while (!frame_done && n < LC + 10);
    chki("latch_len", n, LC);
    chki("latch_bad_cycles", bad, 0);
    if (mode == 0) chki("busy_cycles", bcnt, NL + LC);
  endtask

  typedef struct {
    logic          ra;
    logic          rb;
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;
    logic          grant;
    logic          gb;
    int            mode;
    logic          zap;
  } vec_t;

  vec_t tv[5];

  localparam logic [FW-1:0] PLAN = 120'h00FF00_FF0000_0000FF_FFFFFF_000000;
  localparam logic [FW-1:0] FB1  = 120'h123456_789ABC_DEF012_345678_9ABCDE;
  localparam logic [FW-1:0] FA2  = 120'hA5A5A5_5A5A5A_0F0F0F_F0F0F0_C3C3C3;
  localparam logic [FW-1:0] FB2  = 120'h010203_040506_070809_0A0B0C_0D0E0F;

  initial begin
    logic [FW-1:0] f;
    logic model_last, exp_b;

    tv[0] = '{1'b0, 1'b0, PLAN, FB1, 1'b0, 1'b0, 0, 1'b0};
    tv[1] = '{1'b1, 1'b1, PLAN, FB1, 1'b1, 1'b0, 0, 1'b0};
    tv[2] = '{1'b1, 1'b1, FA2,  FB1, 1'b1, 1'b1, 1, 1'b0};
    tv[3] = '{1'b1, 1'b1, FA2,  FB2, 1'b1, 1'b0, 0, 1'b1};
    tv[4] = '{1'b1, 1'b1, PLAN, FB2, 1'b1, 1'b1, 1, 1'b0};

    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    frame_a = '0; frame_b = '0; px_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chkb("rst_px_valid", px_valid, 1'b0);
    chkd("rst_px_data", px_data, 24'h0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_frame_done", frame_done, 1'b0);
    chkb("rst_last_src", last_src, 1'b1);
    @(negedge clk); reset = 1'b0;

    // Requests are held across frames; grants must alternate and each
    // grant lands on the cycle right after the previous frame_done.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_a = tv[i].ra; req_b = tv[i].rb;
      frame_a = tv[i].fa; frame_b = tv[i].fb; px_ready = 1'b1;
      #2;
      chkb("frame_done_pulse", frame_done, 1'b0);
      if (!tv[i].grant) begin
        chkb("idle_no_gnt", gnt_a | gnt_b, 1'b0);
        chkb("idle_busy", busy, 1'b0);
      end else begin
        do_frame(tv[i].gb ? tv[i].fb : tv[i].fa, tv[i].gb, tv[i].mode, 0, tv[i].zap, 99, 0, 1'b0);
      end
    end
    @(negedge clk); #2;
    chkb("alternate_next_a", gnt_a, 1'b1);

    // Reset mid-SEND, then mid-LATCH.
    @(negedge clk); reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); req_a = 1'b1; frame_a = FA2; px_ready = 1'b1; #2;
    do_frame(FA2, 1'b0, 0, 2, 1'b0, 2, 0, 1'b0);
    @(negedge clk); reset = 1'b1; #2;
    chkd("px2_before_reset", px_data, pix_of(FA2, 2));
    @(negedge clk); reset = 1'b0; #2;
    chkb("rs_px_valid", px_valid, 1'b0);
    chkb("rs_busy", busy, 1'b0);
    chkb("rs_frame_done", frame_done, 1'b0);
    chkd("rs_px_data", px_data, 24'h0);
    chkb("rs_last_src", last_src, 1'b1);
    @(negedge clk); req_a = 1'b1; #2;
    do_frame(FA2, 1'b0, 0, 2, 1'b0, 99, 100, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #2;
    chkb("rl_busy", busy, 1'b0);
    chkb("rl_px_valid", px_valid, 1'b0);
    chkb("rl_last_src", last_src, 1'b1);
    // Tie after reset must go to A even though A won last time.
    @(negedge clk); req_a = 1'b1; req_b = 1'b1; frame_a = PLAN; frame_b = FB1; #2;
    do_frame(PLAN, 1'b0, 0, 2, 1'b0, 99, 0, 1'b0);

    // B raised mid-LATCH of an A frame: served only after frame_done.
    @(negedge clk); #2;
    chkb("post_frame_idle", busy, 1'b0);
    @(negedge clk); req_a = 1'b1; frame_a = FA2; frame_b = FB2; #2;
    do_frame(FA2, 1'b0, 0, 2, 1'b0, 99, 0, 1'b1);
    @(negedge clk); #2;
    chkb("late_gnt_b", gnt_b, 1'b1);
    chkb("late_no_gnt_a", gnt_a, 1'b0);
    @(negedge clk); reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk); reset = 1'b0;

    // Randomized frames, requests and ready; round-robin model.
    model_last = 1'b1;
    for (int fr = 0; fr < 3; fr++) begin
      for (int t = 0; t < 8; t++) begin
        @(negedge clk);
        if (!req_a && !req_b) begin
          req_a = 1'($urandom_range(0, 1));
          req_b = 1'($urandom_range(0, 1));
          if (t >= 3 && !req_a && !req_b) req_b = 1'b1;
        end
        frame_a = rnd_frame(); frame_b = rnd_frame();
        #2;
        if (req_a || req_b) break;
        chkb("rnd_idle_no_gnt", gnt_a | gnt_b, 1'b0);
      end
      exp_b = (req_a && req_b) ? !model_last : req_b;
      f = exp_b ? frame_b : frame_a;
      do_frame(f, exp_b, 2, 1, 1'b0, 99, 0, 1'b0);
      model_last = exp_b;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
